// File: rtl/control_bus_rtc.sv
// Burst master for the RTC's multiplexed address/data bus.
// Each transfer is an address phase, a strobe pulse and a recovery gap; the address auto-increments.
module control_bus_rtc #(
  parameter int unsigned DW       = 8,
  parameter int unsigned LW       = 3,
  parameter int unsigned T_AD     = 4,
  parameter int unsigned T_PULSO  = 4,
  parameter int unsigned T_ESPERA = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          iniciar,
  input  logic          escribe,
  input  logic [DW-1:0] direccion,
  input  logic [LW-1:0] longitud,
  input  logic [DW-1:0] dato,
  output logic          dato_sig,
  input  logic [DW-1:0] bus_in,
  output logic [DW-1:0] bus_out,
  output logic          bus_oe,
  output logic          CS,
  output logic          AD,
  output logic          RD,
  output logic          WR,
  output logic [DW-1:0] dato_leido,
  output logic          dato_valido,
  output logic          ocupado,
  output logic          final_pulso,
  output logic [4:0]    contador
);

  localparam int unsigned CW = 5;

  typedef enum logic [2:0] {S_IDLE, S_DIR, S_PULSO, S_RECUP, S_FIN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_d;
  logic [DW-1:0] addr_q, addr_d;
  logic [DW-1:0] wr_q, wr_d;
  logic [LW-1:0] rest_q, rest_d;
  logic          esc_q, esc_d;

  // Next state, phase counter and burst bookkeeping.
  always_comb begin
    state_d = state_q;
    cnt_d   = contador + CW'(1);
    addr_d  = addr_q;
    rest_d  = rest_q;
    esc_d   = esc_q;
    wr_d    = wr_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (iniciar) begin
          state_d = S_DIR;
          esc_d   = escribe;
          addr_d  = direccion;
          rest_d  = longitud;
        end
      end
      S_DIR: begin
        if (contador == CW'(T_AD - 1)) begin
          state_d = S_PULSO;
          cnt_d   = '0;
          if (esc_q) wr_d = dato;
        end
      end
      S_PULSO: begin
        if (contador == CW'(T_PULSO - 1)) begin
          state_d = S_RECUP;
          cnt_d   = '0;
        end
      end
      S_RECUP: begin
        if (contador == CW'(T_ESPERA - 1)) begin
          cnt_d = '0;
          if (rest_q != '0) begin
            rest_d  = rest_q - LW'(1);
            addr_d  = addr_q + DW'(1);
            state_d = S_DIR;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_FIN: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; bus outputs are decoded from the next state so they align with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      contador    <= '0;
      addr_q      <= '0;
      rest_q      <= '0;
      esc_q       <= 1'b0;
      wr_q        <= '0;
      CS          <= 1'b1;
      AD          <= 1'b1;
      RD          <= 1'b1;
      WR          <= 1'b1;
      bus_oe      <= 1'b0;
      bus_out     <= '0;
      dato_leido  <= '0;
      dato_valido <= 1'b0;
      dato_sig    <= 1'b0;
      final_pulso <= 1'b0;
      ocupado     <= 1'b0;
    end else begin
      state_q     <= state_d;
      contador    <= cnt_d;
      addr_q      <= addr_d;
      rest_q      <= rest_d;
      esc_q       <= esc_d;
      wr_q        <= wr_d;
      CS          <= !((state_d == S_DIR) || (state_d == S_PULSO));
      AD          <= (state_d != S_DIR);
      RD          <= !((state_d == S_PULSO) && !esc_d);
      WR          <= !((state_d == S_PULSO) && esc_d);
      bus_oe      <= (state_d == S_DIR) || ((state_d == S_PULSO) && esc_d);
      if (state_d == S_DIR)                bus_out <= addr_d;
      else if (state_d == S_PULSO && esc_d) bus_out <= wr_d;
      else                                  bus_out <= '0;
      dato_sig    <= (state_q == S_DIR) && (state_d == S_PULSO) && esc_q;
      dato_valido <= (state_q == S_PULSO) && (state_d == S_RECUP) && !esc_q;
      if ((state_q == S_PULSO) && (state_d == S_RECUP) && !esc_q) dato_leido <= bus_in;
      final_pulso <= (state_d == S_FIN);
      ocupado     <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_control_bus_rtc.sv
// Self-checking bench for control_bus_rtc: directed and random bursts on a default
// instance and on a fast-timing instance, compared cycle by cycle with a phase-timing model.
module tb_control_bus_rtc;

  logic       clk = 1'b0;
  logic       reset;
  logic       iniciar, escribe;
  logic [7:0] direccion, dato, bus_in;
  logic [2:0] longitud;
  logic       sel;

  logic       sig_a, oe_a, cs_a, ad_a, rd_a, wr_a, val_a, ocu_a, fin_a;
  logic [7:0] bo_a, lei_a;
  logic [4:0] cnt_a;
  logic       sig_b, oe_b, cs_b, ad_b, rd_b, wr_b, val_b, ocu_b, fin_b;
  logic [7:0] bo_b, lei_b;
  logic [4:0] cnt_b;

  logic ini_a, ini_b;
  assign ini_a = iniciar & ~sel;
  assign ini_b = iniciar & sel;

  always #5 clk = ~clk;

  control_bus_rtc dut_a (
    .clk(clk), .reset(reset), .iniciar(ini_a), .escribe(escribe),
    .direccion(direccion), .longitud(longitud), .dato(dato), .dato_sig(sig_a),
    .bus_in(bus_in), .bus_out(bo_a), .bus_oe(oe_a), .CS(cs_a), .AD(ad_a),
    .RD(rd_a), .WR(wr_a), .dato_leido(lei_a), .dato_valido(val_a),
    .ocupado(ocu_a), .final_pulso(fin_a), .contador(cnt_a)
  );

  control_bus_rtc #(.T_AD(1), .T_PULSO(2), .T_ESPERA(1)) dut_b (
    .clk(clk), .reset(reset), .iniciar(ini_b), .escribe(escribe),
    .direccion(direccion), .longitud(longitud), .dato(dato), .dato_sig(sig_b),
    .bus_in(bus_in), .bus_out(bo_b), .bus_oe(oe_b), .CS(cs_b), .AD(ad_b),
    .RD(rd_b), .WR(wr_b), .dato_leido(lei_b), .dato_valido(val_b),
    .ocupado(ocu_b), .final_pulso(fin_b), .contador(cnt_b)
  );

  // Observed view of whichever instance is under test.
  logic       o_sig, o_oe, o_cs, o_ad, o_rd, o_wr, o_val, o_ocu, o_fin;
  logic [7:0] o_bo, o_lei;
  logic [4:0] o_cnt;
  assign o_sig = sel ? sig_b : sig_a;
  assign o_oe  = sel ? oe_b  : oe_a;
  assign o_cs  = sel ? cs_b  : cs_a;
  assign o_ad  = sel ? ad_b  : ad_a;
  assign o_rd  = sel ? rd_b  : rd_a;
  assign o_wr  = sel ? wr_b  : wr_a;
  assign o_val = sel ? val_b : val_a;
  assign o_ocu = sel ? ocu_b : ocu_a;
  assign o_fin = sel ? fin_b : fin_a;
  assign o_bo  = sel ? bo_b  : bo_a;
  assign o_lei = sel ? lei_b : lei_a;
  assign o_cnt = sel ? cnt_b : cnt_a;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [7:0]  wdata [8];
  logic [7:0]  rdata [8];
  logic [7:0]  model_leido [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
  endtask

  // One burst; expected waveform derived from transfer index and offset within the transfer.
  task automatic run_burst(input bit esc, input logic [7:0] addr, input int len,
                           input int ta, input int tp, input int te, input bit toggle);
    int p, n, total, k, o;
    bit e_dir, e_pul, e_rec, e_fin, e_oe;
    int e_cnt;
    p = ta + tp + te;
    n = len + 1;
    total = n * p + 2;
    @(negedge clk);
    escribe = esc; direccion = addr; longitud = 3'(len); dato = wdata[0]; iniciar = 1'b1;
    @(posedge clk); #1;
    iniciar = 1'b0;
    for (int c = 1; c <= total; c++) begin
      k = (c - 1) / p;
      o = (c - 1) % p;
      e_dir = (c <= n * p) && (o < ta);
      e_pul = (c <= n * p) && (o >= ta) && (o < ta + tp);
      e_rec = (c <= n * p) && (o >= ta + tp);
      e_fin = (c == n * p + 1);
      if (toggle) begin
        iniciar   = (e_dir || e_pul) ? 1'(c % 2) : 1'b0;
        direccion = 8'h33;
      end
      if (esc && e_pul && o == ta && k + 1 < n) dato = wdata[k + 1];
      bus_in = (!esc && e_pul) ? rdata[k] : 8'($urandom);
      @(negedge clk);
      e_oe  = e_dir || (e_pul && esc);
      e_cnt = e_dir ? o : e_pul ? o - ta : e_rec ? o - ta - tp : 0;
      if (!esc && e_rec && o == ta + tp) model_leido[sel] = rdata[k];
      chk($sformatf("c%0d CS", c), 32'(o_cs), 32'(!(e_dir || e_pul)));
      chk($sformatf("c%0d AD", c), 32'(o_ad), 32'(!e_dir));
      chk($sformatf("c%0d RD", c), 32'(o_rd), 32'(!(e_pul && !esc)));
      chk($sformatf("c%0d WR", c), 32'(o_wr), 32'(!(e_pul && esc)));
      chk($sformatf("c%0d bus_oe", c), 32'(o_oe), 32'(e_oe));
      if (e_dir) chk($sformatf("c%0d addr", c), 32'(o_bo), 32'(8'(addr + 8'(k))));
      if (e_pul && esc) chk($sformatf("c%0d wdata", c), 32'(o_bo), 32'(wdata[k]));
      chk($sformatf("c%0d dato_sig", c), 32'(o_sig), 32'(esc && e_pul && o == ta));
      chk($sformatf("c%0d dato_valido", c), 32'(o_val), 32'(!esc && e_rec && o == ta + tp));
      chk($sformatf("c%0d dato_leido", c), 32'(o_lei), 32'(model_leido[sel]));
      chk($sformatf("c%0d final", c), 32'(o_fin), 32'(e_fin));
      chk($sformatf("c%0d ocupado", c), 32'(o_ocu), 32'(c <= n * p + 1));
      chk($sformatf("c%0d contador", c), 32'(o_cnt), 32'(e_cnt));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset = 1'b0; iniciar = 1'b0; escribe = 1'b0; direccion = '0; longitud = '0;
    dato = '0; bus_in = '0; sel = 1'b0;
    model_leido[0] = '0; model_leido[1] = '0;
    #12;
    chk("rst CS", 32'(cs_a), 32'd1);   chk("rst AD", 32'(ad_a), 32'd1);
    chk("rst RD", 32'(rd_a), 32'd1);   chk("rst WR", 32'(wr_a), 32'd1);
    chk("rst bus_oe", 32'(oe_a), 32'd0); chk("rst bus_out", 32'(bo_a), 32'd0);
    chk("rst leido", 32'(lei_a), 32'd0); chk("rst valido", 32'(val_a), 32'd0);
    chk("rst sig", 32'(sig_a), 32'd0);   chk("rst final", 32'(fin_a), 32'd0);
    chk("rst ocupado", 32'(ocu_a), 32'd0); chk("rst contador", 32'(cnt_a), 32'd0);
    chk("rst b CS", 32'(cs_b), 32'd1);   chk("rst b ocupado", 32'(ocu_b), 32'd0);
    @(negedge clk); reset = 1'b1;

    // Single write, then single read.
    wdata[0] = 8'h04;
    run_burst(1'b1, 8'h04, 0, 4, 4, 2, 1'b0);
    rdata[0] = 8'h59;
    run_burst(1'b0, 8'h10, 0, 4, 4, 2, 1'b0);

    // Three-word write burst wrapping the address through FF->00.
    wdata[0] = 8'hA1; wdata[1] = 8'hA2; wdata[2] = 8'hA3;
    run_burst(1'b1, 8'hFE, 2, 4, 4, 2, 1'b0);

    // iniciar and direccion disturbed mid-read must not restart or move the address.
    rdata[0] = 8'h6C; rdata[1] = 8'h3E;
    run_burst(1'b0, 8'h20, 1, 4, 4, 2, 1'b1);

    // Asynchronous reset in the middle of a write strobe.
    @(negedge clk);
    escribe = 1'b1; direccion = 8'h55; longitud = '0; dato = 8'hC3; iniciar = 1'b1;
    @(posedge clk); #1; iniciar = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    chk("pre-reset WR low", 32'(wr_a), 32'd0);
    reset = 1'b0;
    #1;
    chk("async WR", 32'(wr_a), 32'd1); chk("async CS", 32'(cs_a), 32'd1);
    chk("async AD", 32'(ad_a), 32'd1); chk("async bus_oe", 32'(oe_a), 32'd0);
    chk("async ocupado", 32'(ocu_a), 32'd0);
    model_leido[0] = '0; model_leido[1] = '0;
    repeat (3) begin
      @(negedge clk);
      chk("reset held final", 32'(fin_a), 32'd0);
    end
    reset = 1'b1;
    for (int i = 0; i < 8; i++) wdata[i] = 8'($urandom);
    run_burst(1'b1, 8'h55, 0, 4, 4, 2, 1'b0);

    // Fast-timing instance: two-transfer read.
    sel = 1'b1;
    rdata[0] = 8'h81; rdata[1] = 8'h18;
    run_burst(1'b0, 8'h70, 1, 1, 2, 1, 1'b0);

    // Random bursts on both instances.
    for (int r = 0; r < 10; r++) begin
      sel = 1'(r % 2);
      for (int i = 0; i < 8; i++) begin
        wdata[i] = 8'($urandom);
        rdata[i] = 8'($urandom);
      end
      if (sel) run_burst(1'($urandom), 8'($urandom), int'($urandom_range(0, 7)), 1, 2, 1, 1'b0);
      else     run_burst(1'($urandom), 8'($urandom), int'($urandom_range(0, 7)), 4, 4, 2, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
